// File: rtl/texture_upload_arbiter.sv
// Packet-level arbiter: two texture sources share one AXI-Stream write port into the texture buffer.
// Optional round-robin winner selection via `TEXTURE_UPLOAD_ARBITER_ROUND_ROBIN_EN (fixed priority otherwise).
module texture_upload_arbiter #(
   parameter int STREAM_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    resetn,
   input  logic                    pipelineBusy,
   input  logic                    s0_axis_tvalid,
   output logic                    s0_axis_tready,
   input  logic                    s0_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s0_axis_tdata,
   input  logic                    s1_axis_tvalid,
   output logic                    s1_axis_tready,
   input  logic                    s1_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s1_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata,
   output logic                    grant,
   output logic                    uploadActive,
   output logic                    uploadDone
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                         state, state_nxt;
   logic                           grant_nxt;
   logic                           done_nxt;
   logic                           winner;
   logic [1:0]                     src_valid;
   logic [1:0]                     src_last;
   logic [1:0]                     src_ready;
   logic [1:0][STREAM_WIDTH-1:0]   src_data;

   assign src_valid = {s1_axis_tvalid, s0_axis_tvalid};
   assign src_last  = {s1_axis_tlast,  s0_axis_tlast};
   assign src_data  = {s1_axis_tdata,  s0_axis_tdata};

   assign s0_axis_tready = src_ready[0];
   assign s1_axis_tready = src_ready[1];
   assign uploadActive   = (state == BUSY);

`ifdef TEXTURE_UPLOAD_ARBITER_ROUND_ROBIN_EN
   // Contention goes to the port that was not served last; a lone requester always wins.
   always_comb begin
      if (&src_valid) winner = ~grant;
      else            winner = ~src_valid[0];
   end
`else
   // Port 1 only wins when port 0 is not requesting.
   always_comb winner = ~src_valid[0];
`endif

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      done_nxt      = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      src_ready     = 2'b00;
      case (state)
         IDLE: begin
            if ((|src_valid) && !pipelineBusy) begin
               state_nxt = BUSY;
               grant_nxt = winner;
            end
         end
         BUSY: begin
            m_axis_tvalid    = src_valid[grant];
            m_axis_tlast     = src_last[grant];
            m_axis_tdata     = src_data[grant];
            src_ready[grant] = m_axis_tready;
            // pipelineBusy is deliberately ignored here: a started packet always completes.
            if (src_valid[grant] && m_axis_tready && src_last[grant]) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // grant resets to 1 so that round-robin serves port 0 first.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state      <= IDLE;
         grant      <= 1'b1;
         uploadDone <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         uploadDone <= done_nxt;
      end
   end

endmodule

// File: tb/tb_texture_upload_arbiter.sv
// Directed bench for texture_upload_arbiter; expectations follow the build's arbitration mode.
module tb_texture_upload_arbiter;

`ifdef TEXTURE_UPLOAD_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        resetn = 1'b0;
   logic        pipelineBusy = 1'b0;
   logic        s0_axis_tvalid = 1'b0, s0_axis_tready, s0_axis_tlast = 1'b0;
   logic [31:0] s0_axis_tdata = '0;
   logic        s1_axis_tvalid = 1'b0, s1_axis_tready, s1_axis_tlast = 1'b0;
   logic [31:0] s1_axis_tdata = '0;
   logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
   logic [31:0] m_axis_tdata;
   logic        grant, uploadActive, uploadDone;

   int errors = 0;
   int checks = 0;

   texture_upload_arbiter #(.STREAM_WIDTH(32)) dut (
      .aclk(aclk), .resetn(resetn), .pipelineBusy(pipelineBusy),
      .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
      .s0_axis_tlast(s0_axis_tlast), .s0_axis_tdata(s0_axis_tdata),
      .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
      .s1_axis_tlast(s1_axis_tlast), .s1_axis_tdata(s1_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
      .grant(grant), .uploadActive(uploadActive), .uploadDone(uploadDone)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      @(negedge aclk);
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid act=%b exp=0", m_axis_tvalid); end
      checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s0ready act=%b exp=0", s0_axis_tready); end
      checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s1ready act=%b exp=0", s1_axis_tready); end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rst_grant act=%b exp=1", grant); end
      checks++; if (uploadActive !== 1'b0) begin errors++; $display("FAIL rst_active act=%b exp=0", uploadActive); end
      checks++; if (uploadDone !== 1'b0) begin errors++; $display("FAIL rst_done act=%b exp=0", uploadDone); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] exp;
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h11; s0_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      @(negedge aclk);
      checks++; if (uploadActive !== 1'b0) begin errors++; $display("FAIL single_arb_active act=%b exp=0", uploadActive); end
      checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL single_arb_ready act=%b exp=0", s0_axis_tready); end
      tick();
      for (int i = 0; i < 4; i++) begin
         exp = 32'h11 + i;
         s0_axis_tdata = exp; s0_axis_tlast = (i == 3);
         @(negedge aclk);
         checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid%0d act=%b exp=1", i, m_axis_tvalid); end
         checks++; if (m_axis_tdata !== exp) begin errors++; $display("FAIL single_data%0d act=%h exp=%h", i, m_axis_tdata, exp); end
         checks++; if (m_axis_tlast !== (i == 3)) begin errors++; $display("FAIL single_last%0d act=%b exp=%b", i, m_axis_tlast, (i == 3)); end
         checks++; if (s0_axis_tready !== 1'b1) begin errors++; $display("FAIL single_s0ready%0d act=%b exp=1", i, s0_axis_tready); end
         checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL single_s1ready%0d act=%b exp=0", i, s1_axis_tready); end
         checks++; if (grant !== 1'b0) begin errors++; $display("FAIL single_grant%0d act=%b exp=0", i, grant); end
         tick();
      end
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL single_done act=%b exp=1", uploadDone); end
      checks++; if (uploadActive !== 1'b0) begin errors++; $display("FAIL single_idle act=%b exp=0", uploadActive); end
      tick();
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b0) begin errors++; $display("FAIL single_done_pulse act=%b exp=0", uploadDone); end
      tick();
   endtask

   task automatic test_both();
      logic        exp_g;
      logic [31:0] exp_d0, exp_d1;
      exp_g  = RR ? 1'b1 : 1'b0;
      exp_d0 = RR ? 32'hB0 : 32'hC0;
      exp_d1 = RR ? 32'hB1 : 32'hC1;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'hA0; s0_axis_tlast = 1'b0;
      s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'hB0; s1_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      tick();
      @(negedge aclk);
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL both_first_grant act=%b exp=0", grant); end
      checks++; if (m_axis_tdata !== 32'hA0) begin errors++; $display("FAIL both_a0 act=%h exp=a0", m_axis_tdata); end
      checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL both_s1_blocked act=%b exp=0", s1_axis_tready); end
      tick();
      s0_axis_tdata = 32'hA1; s0_axis_tlast = 1'b1;
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'hA1 || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL both_a1 act=%h/%b exp=a1/1", m_axis_tdata, m_axis_tlast); end
      tick();
      if (RR) begin
         s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
      end else begin
         s0_axis_tdata = 32'hC0; s0_axis_tlast = 1'b0;
      end
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL both_gap_done act=%b exp=1", uploadDone); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL both_gap_valid act=%b exp=0", m_axis_tvalid); end
      tick();
      @(negedge aclk);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL both_second_grant act=%b exp=%b", grant, exp_g); end
      checks++; if (m_axis_tdata !== exp_d0) begin errors++; $display("FAIL both_second_d0 act=%h exp=%h", m_axis_tdata, exp_d0); end
      checks++; if (s1_axis_tready !== exp_g) begin errors++; $display("FAIL both_second_s1ready act=%b exp=%b", s1_axis_tready, exp_g); end
      checks++; if (s0_axis_tready !== ~exp_g) begin errors++; $display("FAIL both_second_s0ready act=%b exp=%b", s0_axis_tready, ~exp_g); end
      tick();
      if (RR) begin
         s1_axis_tdata = 32'hB1; s1_axis_tlast = 1'b1;
      end else begin
         s0_axis_tdata = 32'hC1; s0_axis_tlast = 1'b1;
      end
      @(negedge aclk);
      checks++; if (m_axis_tdata !== exp_d1 || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL both_second_d1 act=%h/%b exp=%h/1", m_axis_tdata, m_axis_tlast, exp_d1); end
      tick();
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL both_end_done act=%b exp=1", uploadDone); end
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL both_end_grant act=%b exp=%b", grant, exp_g); end
      tick();
   endtask

   task automatic test_pipeline_busy();
      pipelineBusy = 1'b1;
      s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'h55; s1_axis_tlast = 1'b1; m_axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         checks++; if (s1_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pbusy_hold%0d act=%b/%b exp=0/0", i, s1_axis_tready, m_axis_tvalid); end
         tick();
      end
      pipelineBusy = 1'b0;
      @(negedge aclk);
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pbusy_release_valid act=%b exp=0", m_axis_tvalid); end
      tick();
      @(negedge aclk);
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h55) begin errors++; $display("FAIL pbusy_beat act=%b/%h exp=1/55", m_axis_tvalid, m_axis_tdata); end
      checks++; if (s1_axis_tready !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL pbusy_grant act=%b/%b exp=1/1", s1_axis_tready, grant); end
      tick();
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL pbusy_done act=%b exp=1", uploadDone); end
      tick();
   endtask

   task automatic test_backpressure();
      int          idx;
      int          cyc;
      logic [31:0] exp;
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h21; s0_axis_tlast = 1'b0; m_axis_tready = 1'b0;
      tick();
      idx = 0;
      cyc = 0;
      while (idx < 3 && cyc < 10) begin
         m_axis_tready = (cyc % 2 == 0);
         exp = 32'h21 + idx;
         s0_axis_tdata = exp; s0_axis_tlast = (idx == 2);
         @(negedge aclk);
         checks++; if (s0_axis_tready !== m_axis_tready) begin errors++; $display("FAIL bp_mirror%0d act=%b exp=%b", cyc, s0_axis_tready, m_axis_tready); end
         checks++; if (m_axis_tdata !== exp || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_data%0d act=%h/%b exp=%h/1", cyc, m_axis_tdata, m_axis_tvalid, exp); end
         checks++; if (uploadActive !== 1'b1) begin errors++; $display("FAIL bp_active%0d act=%b exp=1", cyc, uploadActive); end
         if (m_axis_tready) idx++;
         tick();
         cyc++;
      end
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1 || uploadActive !== 1'b0) begin errors++; $display("FAIL bp_complete act=%b/%b exp=1/0", uploadDone, uploadActive); end
      tick();
   endtask

   task automatic test_midpacket();
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h31; s0_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      tick();
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'h31 || grant !== 1'b0) begin errors++; $display("FAIL mid_beat1 act=%h/%b exp=31/0", m_axis_tdata, grant); end
      tick();
      pipelineBusy = 1'b1; s0_axis_tvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checks++; if (m_axis_tvalid !== 1'b0 || uploadActive !== 1'b1 || grant !== 1'b0) begin errors++; $display("FAIL mid_stall%0d act=%b/%b/%b exp=0/1/0", i, m_axis_tvalid, uploadActive, grant); end
         tick();
      end
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h32; s0_axis_tlast = 1'b1;
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'h32 || m_axis_tlast !== 1'b1 || s0_axis_tready !== 1'b1) begin errors++; $display("FAIL mid_last act=%h/%b/%b exp=32/1/1", m_axis_tdata, m_axis_tlast, s0_axis_tready); end
      tick();
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
      s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'h41; s1_axis_tlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checks++; if (uploadActive !== 1'b0 || s1_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_blocked%0d act=%b/%b exp=0/0", i, uploadActive, s1_axis_tready); end
         checks++; if (uploadDone !== (i == 0)) begin errors++; $display("FAIL mid_done%0d act=%b exp=%b", i, uploadDone, (i == 0)); end
         tick();
      end
      pipelineBusy = 1'b0;
      @(negedge aclk);
      checks++; if (uploadActive !== 1'b0) begin errors++; $display("FAIL mid_release act=%b exp=0", uploadActive); end
      tick();
      @(negedge aclk);
      checks++; if (uploadActive !== 1'b1 || grant !== 1'b1 || m_axis_tdata !== 32'h41) begin errors++; $display("FAIL mid_regrant act=%b/%b/%h exp=1/1/41", uploadActive, grant, m_axis_tdata); end
      tick();
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL mid_regrant_done act=%b exp=1", uploadDone); end
      tick();
   endtask

   task automatic test_reset_mid();
      s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'h51; s0_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      tick();
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'h51 || grant !== 1'b0) begin errors++; $display("FAIL rmid_b1 act=%h/%b exp=51/0", m_axis_tdata, grant); end
      tick();
      s0_axis_tdata = 32'h52;
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'h52) begin errors++; $display("FAIL rmid_b2 act=%h exp=52", m_axis_tdata); end
      tick();
      resetn = 1'b0; m_axis_tready = 1'b0; s0_axis_tdata = 32'h53;
      tick();
      resetn = 1'b1; s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b1; s1_axis_tdata = 32'h61; s1_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      @(negedge aclk);
      checks++; if (m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin errors++; $display("FAIL rmid_outs act=%b/%b/%b exp=0/0/0", m_axis_tvalid, s0_axis_tready, s1_axis_tready); end
      checks++; if (grant !== 1'b1 || uploadActive !== 1'b0 || uploadDone !== 1'b0) begin errors++; $display("FAIL rmid_state act=%b/%b/%b exp=1/0/0", grant, uploadActive, uploadDone); end
      tick();
      @(negedge aclk);
      checks++; if (uploadActive !== 1'b1 || grant !== 1'b1 || m_axis_tdata !== 32'h61 || s1_axis_tready !== 1'b1) begin errors++; $display("FAIL rmid_s1b0 act=%b/%b/%h/%b exp=1/1/61/1", uploadActive, grant, m_axis_tdata, s1_axis_tready); end
      tick();
      s1_axis_tdata = 32'h62; s1_axis_tlast = 1'b1;
      @(negedge aclk);
      checks++; if (m_axis_tdata !== 32'h62 || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL rmid_s1b1 act=%h/%b exp=62/1", m_axis_tdata, m_axis_tlast); end
      tick();
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (uploadDone !== 1'b1) begin errors++; $display("FAIL rmid_done act=%b exp=1", uploadDone); end
      tick();
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_both();
      test_pipeline_busy();
      test_backpressure();
      test_midpacket();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/texture_upload_arbiter.md
# texture_upload_arbiter

Packet-level arbiter sharing the single texture-write AXI-Stream input of the texture buffer between two upstream texture sources (port 0: command-stream texture loader, port 1: DMA texture streamer). It grants one complete packet (terminated by `tlast`) at a time. It holds off new packets while `pipelineBusy` is asserted, so that a texture is never overwritten while the sampler still reads it. It sits directly in front of the texture buffer's `s_axis_*` port.

## Interface
- `STREAM_WIDTH`, 32, data width of all three streams.
- `aclk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `pipelineBusy`  in  1  high while primitives using the current texture are in flight; blocks new grants.
- `s0_axis_tvalid` / `s0_axis_tready` / `s0_axis_tlast` / `s0_axis_tdata`  in/out/in/in  1/1/1/STREAM_WIDTH  source 0 stream.
- `s1_axis_tvalid` / `s1_axis_tready` / `s1_axis_tlast` / `s1_axis_tdata`  in/out/in/in  1/1/1/STREAM_WIDTH  source 1 stream.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tlast` / `m_axis_tdata`  out/in/out/out  1/1/1/STREAM_WIDTH  stream to the texture buffer.
- `grant`  out  1  index of the currently or last granted source.
- `uploadActive`  out  1  high while a packet is in progress.
- `uploadDone`  out  1  one-cycle pulse after the last beat of a packet.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - Leave IDLE when (`s0_axis_tvalid` | `s1_axis_tvalid`) & !`pipelineBusy`.
  - The arbitration winner is registered into `grant`; the next state is BUSY.
  - If `pipelineBusy` is high, stay in IDLE regardless of requests.
- BUSY (granted source g):
  - `m_axis_tvalid` = `sg_tvalid`, `m_axis_tlast` = `sg_tlast`, `m_axis_tdata` = `sg_tdata`, `sg_tready` = `m_axis_tready`. This path is combinational with zero added latency.
  - The non-granted source sees `tready` = 0.
  - On the handshake (`m_axis_tvalid` & `m_axis_tready` & `m_axis_tlast`): go to IDLE next cycle and register `uploadDone` = 1 for one cycle.
- `pipelineBusy` is sampled only in IDLE. Asserting it mid-packet does not stall or abort the packet.
- In IDLE, all `tready` = 0, `m_axis_tvalid` = 0, and `m_axis_tdata` / `m_axis_tlast` are don't-care (driven 0).
- Winner selection is defined under Configuration.
- A source deasserting `tvalid` mid-packet simply stalls the master stream; the grant is held until `tlast`.
- Reset mid-packet: the FSM returns to IDLE and the remainder of the packet is neither forwarded nor accepted until re-arbitration. Upstream sources are reset by the same `resetn`.

## Timing
- Reset values: FSM = IDLE, `grant` = 1 (so round-robin favours port 0 first), `uploadActive` = 0, `uploadDone` = 0, `m_axis_tvalid` = 0, `s0_axis_tready` = `s1_axis_tready` = 0.
- Arbitration latency:
  - Request visible in cycle N with `pipelineBusy` low in cycle N → `uploadActive` = 1 and the first beat can transfer in cycle N+1.
  - Minimum gap between packets: last beat at cycle M, IDLE at M+1, next packet's first beat at M+2.
- `uploadActive` = 1 exactly in the BUSY state. `uploadDone` is high in the cycle after the last beat, which coincides with the first IDLE cycle.
- Single-beat packet (`tlast` on the first beat): BUSY for one cycle when `m_axis_tready` = 1.
- Throughput inside a packet: one beat per cycle when source and sink are both ready.

## Configuration
- `TEXTURE_UPLOAD_ARBITER_ROUND_ROBIN_EN`:
  - Defined: round-robin. When both sources request in IDLE, grant the source ≠ `grant`; a single requester always wins.
  - Undefined: fixed priority. Port 0 wins whenever `s0_axis_tvalid` = 1, port 1 only when port 0 is idle. `grant` still reports the winner.

## Test plan
- Single source: s0 sends a 4-beat packet 0x11..0x14 with `m_axis_tready` = 1 → `m_axis_tdata` shows 0x11..0x14 in cycles N+1..N+4, `tlast` on 0x14, `uploadDone` pulses at N+5, `s1_axis_tready` = 0 throughout.
- Both request in the same cycle after reset, each with a 2-beat packet:
  - Round-robin build: s0 is served, then s1, gap of one IDLE cycle.
  - Fixed-priority build with s0 continuously requesting: s1 never granted.
- `pipelineBusy` = 1 for 10 cycles while s1 is valid → no `tready` and `m_axis_tvalid` = 0 for those cycles; first beat one cycle after `pipelineBusy` falls.
- Backpressure: `m_axis_tready` toggling 1/0 during a 3-beat s0 packet → each beat appears exactly once, `s0_axis_tready` mirrors `m_axis_tready`, the packet completes in 5–6 cycles.
- Mid-packet `pipelineBusy` and source stall: assert `pipelineBusy` after beat 1 and drop `s0_axis_tvalid` for 3 cycles → grant held, packet completes, then no new grant until `pipelineBusy` = 0.
- Reset after beat 2 of 4 → next cycle all outputs at reset values; a new s1 packet is subsequently forwarded intact.
